// File: rtl/sdr_hdr_transition_top.sv
// sdr_hdr_transition_top: SDR controller that enters HDR-DDR/CCC engines or broadcasts DISEC hot-join
// Ports: i_sdr_clk/i_sdr_rst_n clock and async active-low reset; i_controller_en, i_i3c_i2c_sel,
// i_hdr_en, i_ccc_en_dis_hj request controls; i_regf_* and i_data_config_mux_sel host regfile port;
// i_ddr_mode_done/i_ccc_done/i_*_pp_od engine handshake; o_ddrmode_enable/o_ccc_enable engine
// enables; o_regf_address_special descriptor pointer; o_sdr_rx_valid ACK pulse; o_ctrl_done end
// pulse; scl bus clock; sda open-drain bus data.
module sdr_hdr_transition_top #(
  parameter logic [11:0] CONFIG_LOC = 12'd1000
) (
  input  logic        i_sdr_clk,
  input  logic        i_sdr_rst_n,
  input  logic        i_controller_en,
  input  logic        i_i3c_i2c_sel,
  input  logic        i_hdr_en,
  input  logic        i_ccc_en_dis_hj,
  input  logic [7:0]  i_regf_config,
  input  logic [11:0] i_regf_wr_address_config,
  input  logic        i_regf_wr_en_config,
  input  logic        i_regf_rd_en_config,
  input  logic        i_data_config_mux_sel,
  input  logic        i_ddr_mode_done,
  input  logic        i_ccc_done,
  input  logic        i_ddr_pp_od,
  input  logic        i_ccc_pp_od,
  output logic        o_ddrmode_enable,
  output logic        o_ccc_enable,
  output logic [11:0] o_regf_address_special,
  output logic        o_sdr_rx_valid,
  output logic        o_ctrl_done,
  output logic        scl,
  inout  wire         sda
);
  localparam logic [3:0] IDLE = 4'd0, READ_CFG = 4'd1, START = 4'd2, ADDR = 4'd3, ACK = 4'd4,
    CCC = 4'd5, PARITY = 4'd6, ENGINE = 4'd7, EXIT = 4'd8, STOP = 4'd9, DONE = 4'd10;
  logic [7:0] mem [0:4095];
  logic [3:0] state, nxt;
  logic [1:0] ph;
  logic [2:0] cnt, mode;
  logic       cp, toc, hdr, dat, ack, armed, abort;
  logic       sda_lo, sda_hi, bit_end, live, eng_done;
  logic [7:0] rd, cur_byte;
  logic       unused;
  always_ff @(posedge i_sdr_clk)
    if (i_data_config_mux_sel && i_regf_wr_en_config) mem[i_regf_wr_address_config] <= i_regf_config;
  assign rd       = mem[ph[0] ? CONFIG_LOC + 12'd3 : CONFIG_LOC + 12'd1];
  assign unused   = ^{i_regf_rd_en_config, rd[6:5], rd[1:0]};
  assign bit_end  = ph == 2'd3;
  assign live     = i_controller_en && i_i3c_i2c_sel;
  assign eng_done = cp ? i_ccc_done : i_ddr_mode_done;
  assign cur_byte = state == ADDR ? 8'hFC : dat ? 8'h08 : hdr ? 8'h20 : 8'h01;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (live && !i_data_config_mux_sel && (i_hdr_en || i_ccc_en_dis_hj) && armed) nxt = READ_CFG;
      READ_CFG: if (ph[0]) nxt = START;
      START:    if (bit_end) nxt = ADDR;
      ADDR:     if (bit_end && cnt == 3'd7) nxt = ACK;
      ACK:      if (bit_end) nxt = (!ack || (hdr && mode != 3'd6)) ? STOP : CCC;
      CCC:      if (bit_end && cnt == 3'd7) nxt = PARITY;
      PARITY:   if (bit_end) nxt = hdr ? ENGINE : dat ? STOP : CCC;
      ENGINE:   if (eng_done) nxt = toc ? EXIT : STOP;
      EXIT:     if (bit_end && cnt == 3'd3) nxt = STOP;
      STOP:     if (bit_end) nxt = abort ? IDLE : DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (!live && state != IDLE && state != STOP && state != DONE) nxt = STOP;
  end
  // Bit slots are 4 clocks: SCL low for ph 0-1, high for ph 2-3; data changes at ph 0.
  always_comb begin
    scl    = 1'b1;
    sda_lo = 1'b0;
    case (state)
      START:         sda_lo = ph[1];
      ADDR, CCC:     begin scl = ph[1]; sda_lo = ~cur_byte[~cnt]; end
      ACK, ENGINE:   scl = ph[1];
      PARITY:        begin scl = ph[1]; sda_lo = ^cur_byte; end
      EXIT:          begin scl = 1'b0; sda_lo = ~ph[1]; end
      STOP:          begin scl = ph != 2'd0; sda_lo = ~ph[1]; end
      default:       scl = 1'b1;
    endcase
  end
  assign sda_hi = state == ENGINE && (cp ? i_ccc_pp_od : i_ddr_pp_od);
  assign sda    = sda_lo ? 1'b0 : sda_hi ? 1'b1 : 1'bz;
  assign o_regf_address_special = state == ENGINE ? CONFIG_LOC : 12'd0;
  assign o_ctrl_done = state == DONE;
  always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n)
    if (!i_sdr_rst_n) begin
      state            <= IDLE;
      ph               <= 2'd0;
      cnt              <= 3'd0;
      cp               <= 1'b0;
      toc              <= 1'b0;
      mode             <= 3'd0;
      hdr              <= 1'b0;
      dat              <= 1'b0;
      ack              <= 1'b0;
      armed            <= 1'b0;
      abort            <= 1'b0;
      o_sdr_rx_valid   <= 1'b0;
      o_ddrmode_enable <= 1'b0;
      o_ccc_enable     <= 1'b0;
    end else begin
      state            <= nxt;
      ph               <= nxt != state ? 2'd0 : ph + 2'd1;
      cnt              <= nxt != state ? 3'd0 : cnt + {2'b0, bit_end};
      cp               <= state == READ_CFG && !ph[0] ? rd[7] : cp;
      toc              <= state == READ_CFG && ph[0] ? rd[7] : toc;
      mode             <= state == READ_CFG && ph[0] ? rd[4:2] : mode;
      hdr              <= state == IDLE ? i_hdr_en : hdr;
      dat              <= state == IDLE ? 1'b0 : (state == PARITY && nxt == CCC) ? 1'b1 : dat;
      ack              <= state == ACK && ph == 2'd2 ? ~sda : ack;
      // A request must be seen low once before it can start another transaction.
      armed            <= (!i_hdr_en && !i_ccc_en_dis_hj) ? 1'b1 : (nxt == READ_CFG) ? 1'b0 : armed;
      abort            <= state == IDLE ? 1'b0 : (!live && nxt == STOP) ? 1'b1 : abort;
      o_sdr_rx_valid   <= state == ACK && bit_end && ack;
      o_ddrmode_enable <= nxt == ENGINE && !cp;
      o_ccc_enable     <= nxt == ENGINE && cp;
    end
endmodule

// File: tb/tb_sdr_hdr_transition_top.sv
// tb_sdr_hdr_transition_top: randomized bus-level checks of sdr_hdr_transition_top against a protocol model
module tb_sdr_hdr_transition_top;
  logic clk = 1'b0, rst_n = 1'b1;
  logic en = 1'b0, sel = 1'b0, hdr_en = 1'b0, hj = 1'b0;
  logic [7:0] cfg = 8'd0;
  logic [11:0] waddr = 12'd0;
  logic wr_en = 1'b0, rd_en = 1'b0, msel = 1'b0;
  logic ddr_done = 1'b0, ccc_done = 1'b0, ddr_pp = 1'b0, ccc_pp = 1'b0;
  wire ddr_en, ccc_en, rxv, cdone, scl, sda;
  wire [11:0] raddr;
  logic tgt_low = 1'b0;
  bit ack_en = 1'b0;
  int total = 0, passed = 0;
  int starts = 0, stops = 0, lowfalls = 0, dcnt = 0, rcnt = 0, sclow = 0, ens = 0, nb = 0;
  logic pscl = 1'b1, psda = 1'b1;
  logic bits[$];
  logic exp_q[$];

  pullup (sda);
  assign sda = tgt_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;

  sdr_hdr_transition_top dut (
    .i_sdr_clk(clk), .i_sdr_rst_n(rst_n), .i_controller_en(en), .i_i3c_i2c_sel(sel),
    .i_hdr_en(hdr_en), .i_ccc_en_dis_hj(hj), .i_regf_config(cfg),
    .i_regf_wr_address_config(waddr), .i_regf_wr_en_config(wr_en), .i_regf_rd_en_config(rd_en),
    .i_data_config_mux_sel(msel), .i_ddr_mode_done(ddr_done), .i_ccc_done(ccc_done),
    .i_ddr_pp_od(ddr_pp), .i_ccc_pp_od(ccc_pp), .o_ddrmode_enable(ddr_en), .o_ccc_enable(ccc_en),
    .o_regf_address_special(raddr), .o_sdr_rx_valid(rxv), .o_ctrl_done(cdone), .scl(scl), .sda(sda)
  );

  // Bus monitor and acknowledging target: decodes bits on SCL rise, START/STOP while SCL high.
  always @(negedge clk) begin
    logic cs, cd;
    cs = scl;
    cd = sda;
    if (pscl && cs && psda && !cd) begin starts++; bits.delete(); nb = 0; end
    else if (pscl && cs && !psda && cd) begin stops++; if (bits.size() > 0) void'(bits.pop_back()); end
    if (!pscl && cs) begin bits.push_back(cd); nb++; end
    if (pscl && !cs) tgt_low = ack_en && nb == 8;
    if (!cs && psda && !cd) lowfalls++;
    if (cdone) dcnt++;
    if (rxv) rcnt++;
    if (!cs) sclow++;
    if (ddr_en || ccc_en) ens++;
    pscl = cs;
    psda = cd;
  end

  function automatic bit tpar(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic build_exp(input bit hdr, input bit m6, input bit ack);
    exp_q.delete();
    push_byte(8'hFC);
    exp_q.push_back(!ack);
    if (ack && hdr && m6) begin push_byte(8'h20); exp_q.push_back(tpar(8'h20)); end
    else if (ack && !hdr) begin
      push_byte(8'h01); exp_q.push_back(tpar(8'h01));
      push_byte(8'h08); exp_q.push_back(tpar(8'h08));
    end
  endtask

  task automatic wr_cfg(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk); msel = 1'b1; waddr = a; cfg = d; wr_en = 1'b1;
    @(negedge clk); wr_en = 1'b0; msel = 1'b0;
  endtask

  task automatic wait_engine();
    for (int t = 0; t < 400 && !(ddr_en || ccc_en); t++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_stop(input int st0);
    for (int t = 0; t < 400 && stops == st0; t++) begin @(negedge clk); #1; end
  endtask

  task automatic run_txn(input bit hdr, input logic [7:0] b1, input logic [7:0] b3, input bit pp,
                         input bit ack, input int eng_len);
    bit cp, toc, eng, bad;
    int s0, st0, d0, r0, e0, lf0;
    cp = b1[7];
    toc = b3[7];
    eng = hdr && ack && b3[4:2] == 3'd6;
    wr_cfg(12'd1001, b1);
    wr_cfg(12'd1003, b3);
    ack_en = ack; ddr_pp = pp; ccc_pp = pp;
    build_exp(hdr, b3[4:2] == 3'd6, ack);
    @(negedge clk); #1;
    s0 = starts; st0 = stops; d0 = dcnt; r0 = rcnt; e0 = ens;
    hdr_en = hdr; hj = !hdr;
    if (eng) wait_engine(); else wait_stop(st0);
    total++;
    if (eng ? !(ddr_en || ccc_en) : stops == st0) $display("FAIL txn_timeout: engine=%0b not reached", eng);
    else passed++;
    bad = bits.size() != exp_q.size();
    for (int i = 0; i < exp_q.size() && i < bits.size(); i++) bad |= bits[i] !== exp_q[i];
    total++;
    if (bad) $display("FAIL bus_bits: got %0d bits, required %0d bits (hdr=%0b ack=%0b)", bits.size(), exp_q.size(), hdr, ack);
    else passed++;
    if (eng) begin
      total++;
      if (ddr_en !== !cp || ccc_en !== cp || raddr !== 12'd1000)
        $display("FAIL engine_sel: ddr=%b ccc=%b addr=%0d required ddr=%b ccc=%b addr=1000", ddr_en, ccc_en, raddr, !cp, cp);
      else passed++;
      repeat (eng_len) @(negedge clk);
      if (cp) ddr_done = 1'b1; else ccc_done = 1'b1;
      @(negedge clk); ddr_done = 1'b0; ccc_done = 1'b0;
      @(negedge clk); #1;
      total++;
      if ((ddr_en || ccc_en) !== 1'b1 || sda !== 1'b1)
        $display("FAIL engine_hold: en=%b sda=%b required en=1 sda=1", ddr_en || ccc_en, sda);
      else passed++;
      lf0 = lowfalls;
      if (cp) ccc_done = 1'b1; else ddr_done = 1'b1;
      @(negedge clk); #1;
      ddr_done = 1'b0; ccc_done = 1'b0;
      total++;
      if (ddr_en !== 1'b0 || ccc_en !== 1'b0 || raddr !== 12'd0)
        $display("FAIL engine_exit: ddr=%b ccc=%b addr=%0d required all 0", ddr_en, ccc_en, raddr);
      else passed++;
      wait_stop(st0);
      total++;
      if (lowfalls - lf0 !== 4 * toc + 1)
        $display("FAIL exit_falls: got %0d falls before STOP, required %0d", lowfalls - lf0, 4 * toc + 1);
      else passed++;
    end else begin
      total++;
      if (ens != e0) $display("FAIL no_engine: enable high for %0d cycles, required 0", ens - e0);
      else passed++;
    end
    repeat (12) @(negedge clk);
    #1;
    total++;
    if (dcnt - d0 != 1 || rcnt - r0 != int'(ack))
      $display("FAIL pulses: ctrl_done=%0d rx_valid=%0d required 1 and %0d", dcnt - d0, rcnt - r0, ack);
    else passed++;
    total++;
    if (starts - s0 != 1 || scl !== 1'b1 || sda !== 1'b1)
      $display("FAIL rearm: starts=%0d scl=%b sda=%b required 1 start then idle bus", starts - s0, scl, sda);
    else passed++;
    hdr_en = 1'b0; hj = 1'b0; ack_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (ddr_en !== 0 || ccc_en !== 0 || rxv !== 0 || cdone !== 0 || raddr !== 0 || scl !== 1 || sda !== 1)
      $display("FAIL reset_outputs: ddr=%b ccc=%b rxv=%b done=%b addr=%0d scl=%b sda=%b required 0s, scl=1 sda=1",
               ddr_en, ccc_en, rxv, cdone, raddr, scl, sda);
    else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; en = 1'b1; sel = 1'b1;
  endtask

  task automatic test_hdr_ddr();
    logic [7:0] d [8];
    d = '{8'h00, 8'h00, 8'h00, 8'h98, 8'h00, 8'h8A, 8'h5A, 8'hFF};
    for (int i = 0; i < 8; i++) wr_cfg(12'd1000 + 12'(i), d[i]);
    run_txn(1'b1, d[1], d[3], 1'b0, 1'b1, 20);
  endtask

  task automatic test_nack();
    run_txn(1'b1, 8'h00, 8'h98, 1'b0, 1'b0, 0);
  endtask

  task automatic test_ccc_engine();
    run_txn(1'b1, 8'h80, 8'h98, 1'b1, 1'b1, 15);
  endtask

  task automatic test_disec();
    run_txn(1'b0, 8'h00, 8'h98, 1'b0, 1'b1, 0);
  endtask

  task automatic test_mode_not6();
    run_txn(1'b1, 8'h00, 8'h94, 1'b0, 1'b1, 0);
  endtask

  task automatic test_i2c_ignored();
    int s0, c0;
    sel = 1'b0; hdr_en = 1'b1;
    @(negedge clk); #1;
    s0 = starts; c0 = sclow;
    repeat (40) @(negedge clk);
    #1;
    total++;
    if (starts != s0 || sclow != c0 || scl !== 1'b1 || sda !== 1'b1)
      $display("FAIL i2c_ignored: starts=%0d scl_low=%0d scl=%b sda=%b required no activity", starts - s0, sclow - c0, scl, sda);
    else passed++;
    hdr_en = 1'b0;
    @(negedge clk); sel = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int st0, d0;
    wr_cfg(12'd1001, 8'h00);
    wr_cfg(12'd1003, 8'h98);
    ack_en = 1'b1;
    @(negedge clk);
    st0 = stops; d0 = dcnt;
    hdr_en = 1'b1;
    wait_engine();
    total++;
    if (ddr_en !== 1'b1) $display("FAIL abort_engine: ddr=%b required 1", ddr_en); else passed++;
    en = 1'b0;
    wait_stop(st0);
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (stops == st0 || dcnt != d0 || ddr_en !== 1'b0 || scl !== 1'b1 || sda !== 1'b1)
      $display("FAIL abort_stop: stops=%0d done=%0d ddr=%b scl=%b sda=%b required STOP, no done", stops - st0, dcnt - d0, ddr_en, scl, sda);
    else passed++;
    hdr_en = 1'b0; ack_en = 1'b0;
    @(negedge clk); en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_in_engine();
    ack_en = 1'b1;
    @(negedge clk); hdr_en = 1'b1;
    wait_engine();
    total++;
    if (ddr_en !== 1'b1) $display("FAIL rst_engine_reach: ddr=%b required 1", ddr_en); else passed++;
    @(posedge clk); #2;
    rst_n = 1'b0; hdr_en = 1'b0; ack_en = 1'b0;
    #1;
    total++;
    if (ddr_en !== 0 || ccc_en !== 0 || raddr !== 0 || cdone !== 0 || rxv !== 0 || scl !== 1 || sda !== 1)
      $display("FAIL rst_engine: ddr=%b ccc=%b addr=%0d scl=%b sda=%b required 0s, scl=1 sda=1", ddr_en, ccc_en, raddr, scl, sda);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b1, b3;
      logic [2:0] m;
      bit h, a;
      h = $urandom_range(0, 9) < 7;
      a = $urandom_range(0, 9) < 8;
      m = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) m = 3'd6;
      b1 = 8'($urandom);
      b3 = {1'($urandom), 2'($urandom), m, 2'($urandom)};
      run_txn(h, b1, b3, 1'($urandom), a, $urandom_range(2, 30));
    end
  endtask

  initial begin
    test_reset();
    test_hdr_ddr();
    test_nack();
    test_ccc_engine();
    test_disec();
    test_mode_not6();
    test_i2c_ignored();
    test_abort();
    test_reset_in_engine();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
